// File: rtl/mux_2_burst_arbiter_pkg.sv
// Shared definitions for the two-requester burst arbiter: FSM state encoding,
// default widths and the round-robin pick used when leaving IDLE.
package mux_2_burst_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_LEN_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // Requester that wins in IDLE; on a tie the one that did not own the last burst.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_owner);
    return (req0 && req1) ? ~last_owner : req1;
  endfunction

endpackage

// File: rtl/mux_2_for_32_bits.sv
// Fixed 32-bit two-input datapath mux driven by the arbiter's select.
module mux_2_for_32_bits (
  output logic [31:0] out_data_o,
  input  logic [31:0] d0_i,
  input  logic [31:0] d1_i,
  input  logic        select_i
);

  assign out_data_o = select_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_2_burst_arbiter.sv
// Round-robin burst arbiter sharing one 32-bit path between two requesters,
// with a valid/ready handshake towards the single consumer.
module mux_2_burst_arbiter
  import mux_2_burst_arbiter_pkg::*;
#(
  // The datapath mux is a fixed 32-bit cell, so DATA_W must stay 32.
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned LEN_W  = DEFAULT_LEN_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [LEN_W-1:0]  len0_i,
  input  logic [LEN_W-1:0]  len1_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              select_o,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              done_o,
  output logic              abort_o
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic xfer;
  logic owner_req;
  logic accept;

  assign xfer      = (state_q == ST_XFER);
  assign owner_req = owner_q ? req1_i : req0_i;
  // A dropped request ends the burst before any handshake, so no beat is offered.
  assign accept    = xfer && owner_req && out_ready_i;

  assign out_valid_o = xfer && owner_req;
  assign select_o    = owner_q;
  assign gnt0_o      = xfer && !owner_q;
  assign gnt1_o      = xfer &&  owner_q;
  assign ack0_o      = accept && !owner_q;
  assign ack1_o      = accept &&  owner_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;

  mux_2_for_32_bits u_mux (
    .out_data_o (out_data_o),
    .d0_i       (d0_i),
    .d1_i       (d1_i),
    .select_i   (owner_q)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          owner_d    = rr_pick(req0_i, req1_i, last_owner_q);
          len_d      = owner_d ? len1_i : len0_i;
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!owner_req) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          abort_d      = 1'b1;
        end else if (out_ready_i) begin
          // Terminal compare precedes the increment, so beat_cnt never wraps.
          if (beat_cnt_q == len_q) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
            done_d       = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_mux_2_burst_arbiter.sv
// Directed bench for the burst arbiter: stimulus queues expected beats and
// done/abort pulses; a negedge monitor pops and compares them as they appear.
module tb_mux_2_burst_arbiter;

  typedef enum logic [1:0] {EV_BEAT = 2'd0, EV_DONE = 2'd1, EV_ABORT = 2'd2} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic        owner;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  len0 = '0, len1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, select, gnt0, gnt1, ack0, ack1, done, abort;

  int n_vec = 0;
  int n_err = 0;
  ev_t exp_q[$];

  mux_2_burst_arbiter #(.DATA_W(32), .LEN_W(2)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req0_i      (req0),
    .req1_i      (req1),
    .len0_i      (len0),
    .len1_i      (len1),
    .d0_i        (d0),
    .d1_i        (d1),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .select_o    (select),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .ack0_o      (ack0),
    .ack1_o      (ack1),
    .done_o      (done),
    .abort_o     (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input ev_e k, input logic o, input logic [31:0] d);
    ev_t e;
    e.kind  = k;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_e k, input logic o, input logic [31:0] d);
    ev_t e;
    ev_t got;
    got.kind  = k;
    got.owner = o;
    got.data  = d;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got event %0h with nothing expected (t=%0t)", got, $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_event", 64'(got), 64'(e));
    end
  endtask

  // Monitor: samples on the falling edge, ignores cycles held in reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
      check("pulse_exclusive", 64'(done & abort), 64'd0);
      if (ack0 | ack1) observe(EV_BEAT, ack1, out_data);
      if (done)        observe(EV_DONE, select, 32'd0);
      if (abort)       observe(EV_ABORT, select, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pat[7];
    int acked;
    pat = '{1, 0, 0, 1, 1, 0, 1};

    // 1: reset state, then a single-beat burst from requester 0
    reset = 1'b1;
    step();
    step();
    check("t1_reset_state", 64'({gnt0, gnt1, out_valid, select, done, abort}), 64'd0);
    reset = 1'b0; req0 = 1'b1; len0 = 2'd0; d0 = 32'hDEADBEEF; out_ready = 1'b1;
    push(EV_BEAT, 1'b0, 32'hDEADBEEF);
    push(EV_DONE, 1'b0, 32'd0);
    step();
    check("t1_gnt", 64'({gnt0, gnt1}), 64'b10);
    check("t1_data", 64'(out_data), 64'hDEADBEEF);
    check("t1_ack0", 64'(ack0), 64'd1);
    step();
    check("t1_done_gnt0", 64'({done, gnt0}), 64'b10);
    req0 = 1'b0;
    step();

    // 2: both requesting continuously, two-beat bursts, strict alternation
    reset = 1'b1;
    step();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 2'd1; len1 = 2'd1;
    d0 = 32'hA0A0_0000; d1 = 32'hB1B1_1111; out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      logic o;
      o = (b == 1);
      push(EV_BEAT, o, o ? 32'hB1B1_1111 : 32'hA0A0_0000);
      push(EV_BEAT, o, o ? 32'hB1B1_1111 : 32'hA0A0_0000);
      push(EV_DONE, o, 32'd0);
    end
    step();
    check("t2_first_sel", 64'({select, gnt0, gnt1}), 64'b010);
    step();
    step();
    check("t2_bubble", 64'({out_valid, done}), 64'b01);
    step();
    check("t2_second_sel", 64'({select, gnt0, gnt1}), 64'b101);
    step();
    step();
    step();
    check("t2_third_sel", 64'({select, gnt0, gnt1}), 64'b010);
    step();
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();

    // 3: four-beat burst from requester 1 with consumer stalls
    req1 = 1'b1; len1 = 2'd3; d1 = 32'h1000_0000; out_ready = 1'b0;
    step();
    acked = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      d1 = 32'h1000_0000 + 32'(acked);
      #1;
      check("t3_ack1", 64'(ack1), 64'(pat[i][0]));
      if (pat[i] != 0) begin
        push(EV_BEAT, 1'b1, d1);
        acked++;
      end
      step();
    end
    push(EV_DONE, 1'b1, 32'd0);
    // the done pulse above is observed during this cycle's negedge
    check("t3_done", 64'({done, gnt1}), 64'b10);
    req1 = 1'b0; out_ready = 1'b1;
    step();

    // 4: owner drops request mid-burst, other requester then granted
    req0 = 1'b1; req1 = 1'b1; len0 = 2'd3; len1 = 2'd0;
    d0 = 32'h4000_0000; d1 = 32'h4111_1111; out_ready = 1'b1;
    push(EV_BEAT, 1'b0, 32'h4000_0000);
    push(EV_BEAT, 1'b0, 32'h4000_0000);
    push(EV_ABORT, 1'b0, 32'd0);
    push(EV_BEAT, 1'b1, 32'h4111_1111);
    push(EV_DONE, 1'b1, 32'd0);
    step();
    step();
    step();
    req0 = 1'b0;
    #1;
    check("t4_no_ack_on_drop", 64'({ack0, ack1}), 64'b00);
    step();
    check("t4_abort", 64'({abort, done, gnt0, gnt1}), 64'b1000);
    step();
    check("t4_gnt1", 64'({gnt0, gnt1}), 64'b01);
    step();
    check("t4_done", 64'(done), 64'd1);
    req1 = 1'b0;
    step();

    // 5: reset in the middle of a four-beat burst
    req0 = 1'b1; len0 = 2'd3; d0 = 32'h5000_0000; out_ready = 1'b1;
    push(EV_BEAT, 1'b0, 32'h5000_0000);
    step();
    step();
    reset = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
    step();
    check("t5_after_reset", 64'({gnt0, gnt1, out_valid, select, done, abort}), 64'd0);
    reset = 1'b0;
    push(EV_BEAT, 1'b0, 32'h5000_0000);
    push(EV_DONE, 1'b0, 32'd0);
    step();
    check("t5_req0_wins", 64'({gnt0, gnt1}), 64'b10);
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();

    // 6: len changes while granted; the sampled length still governs
    req0 = 1'b1; len0 = 2'd0; d0 = 32'h6000_0006; out_ready = 1'b0;
    push(EV_BEAT, 1'b0, 32'h6000_0006);
    push(EV_DONE, 1'b0, 32'd0);
    step();
    len0 = 2'd3;
    step();
    out_ready = 1'b1;
    step();
    check("t6_done_one_beat", 64'({done, gnt0}), 64'b10);
    req0 = 1'b0;
    step();
    step();
    step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
